// File: rtl/cbus_ram_responder_pkg.sv
// Shared cbus types and responder state encodings.
package cbus_ram_responder_pkg;

  typedef logic [3:0] mlen_t;
  typedef logic [3:0] strb_t;

  typedef enum logic {
    CBUS_INCR = 1'b0,
    CBUS_WRAP = 1'b1
  } cbus_burst_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    strb_t       strobe;
    logic [31:0] data;
    mlen_t       len;
    cbus_burst_e burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/cbus_ram_responder_if.sv
// cbus request/response bundle between a cache initiator and a responder.
interface cbus_ram_responder_if;
  import cbus_ram_responder_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input  cresp);
  modport slave  (input  creq, output cresp);
endinterface

// File: rtl/cbus_ram_responder_ram_bank.sv
// Byte-strobed single-port RAM with an extra asynchronous debug read port.
module cbus_ram_bank
  import cbus_ram_responder_pkg::*;
#(
  parameter  int MEM_WORDS = 1024,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  strb_t         i_strb,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [31:0]   o_dbg_data
);

  logic [31:0] r_mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_strb[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Both read ports see the pre-edge contents during a write beat.
  assign o_rdata    = r_mem[i_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/cbus_ram_responder.sv
// cbus responder backed by internal RAM with configurable first-beat latency.
// Optional protocol checker enabled by defining CBUS_RAM_CHECK_EN.
module cbus_ram_responder
  import cbus_ram_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  cbus_ram_responder_if.slave          cbus,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  output logic [31:0]                  dbg_data,
  output logic                         err
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [1:0]    r_state;
  logic [15:0]   r_cnt;
  mlen_t         r_beat;
  logic [AW-1:0] r_word;
  mlen_t         r_len;
  cbus_burst_e   r_burst;
  logic          r_is_write;

  logic          w_accept;
  logic          w_ready;
  logic          w_last;
  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  cbus_resp_t    w_resp;
  logic          w_unused;

  assign w_accept = (r_state == ST_IDLE) && cbus.creq.valid;
  assign w_ready  = (r_state == ST_BURST);
  assign w_last   = w_ready && (r_beat == r_len);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_beat <= '0;
          if (cbus.creq.valid) begin
            if (LATENCY == 0) begin
              r_state <= ST_BURST;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= 16'(LATENCY);
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt <= 16'd1) r_state <= ST_BURST;
        end
        ST_BURST: begin
          if (r_beat == r_len) begin
            r_state <= ST_DRAIN;
            r_beat  <= '0;
          end else begin
            r_beat <= r_beat + mlen_t'(1);
          end
        end
        default: begin
          if (!cbus.creq.valid) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_word     <= cbus.creq.addr[AW+1:2];
      r_len      <= cbus.creq.len;
      r_burst    <= cbus.creq.burst;
      r_is_write <= cbus.creq.is_write;
    end
  end

  // WRAP keeps the upper bits of the start word and cycles the low log2(len+1) bits.
  assign w_mask = AW'(r_len);
  assign w_inc  = r_word + AW'(r_beat);
  assign w_idx  = (r_burst == CBUS_WRAP) ? ((r_word & ~w_mask) | (w_inc & w_mask)) : w_inc;

  cbus_ram_bank #(.MEM_WORDS(MEM_WORDS)) u_bank (
    .clk        (clk),
    .i_we       (w_ready && r_is_write),
    .i_addr     (w_idx),
    .i_strb     (cbus.creq.strobe),
    .i_wdata    (cbus.creq.data),
    .o_rdata    (w_rdata),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  always_comb begin
    w_resp       = '0;
    w_resp.ready = w_ready;
    w_resp.last  = w_last;
    w_resp.data  = (w_ready && !r_is_write) ? w_rdata : 32'd0;
  end
  assign cbus.cresp = w_resp;

  // size is informational only; strobe alone selects the bytes written.
  assign w_unused = ^{cbus.creq.size, cbus.creq.addr[31:AW+2], cbus.creq.addr[1:0]};

`ifdef CBUS_RAM_CHECK_EN
  logic [31:0] r_addr_full;
  logic        r_err;
  logic        w_viol;

  always_ff @(posedge clk) begin
    if (w_accept) r_addr_full <= cbus.creq.addr;
  end

  assign w_viol = ((r_state == ST_WAIT) || (r_state == ST_BURST)) &&
                  ((cbus.creq.addr != r_addr_full) || (cbus.creq.len != r_len) ||
                   (cbus.creq.burst != r_burst) || (cbus.creq.is_write != r_is_write) ||
                   (!cbus.creq.valid && !w_last));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_err <= 1'b0;
    else if (w_viol) r_err <= 1'b1;
  end
  assign err = r_err;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (resetn && w_viol && !r_err) $error("cbus request changed or dropped mid-burst");
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench for cbus_ram_responder with a cycle-timeline reference model.
module tb_cbus_ram_responder;
  import cbus_ram_responder_pkg::*;

  localparam int MW  = 1024;
  localparam int LAT = 2;
  localparam int AW  = 10;
  localparam int NC  = 4096;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_data;
  logic          err;

  always #5 clk = ~clk;

  cbus_ram_responder_if bus ();

  cbus_ram_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cbus     (bus.slave),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .err      (err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output timeline, indexed by cycle number.
  bit          s_rdy [NC];
  bit          s_last[NC];
  bit          s_chk [NC];
  logic [31:0] s_dat [NC];

  // Reference memory contents and which words are known.
  logic [31:0] mm [MW];
  bit          mk [MW];
  logic [31:0] wdat [16];
  logic        exp_err = 1'b0;

  logic [31:0] obs_d[$];
  int          obs_c[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < NC) begin
      chk("ready", 32'(bus.cresp.ready), 32'(s_rdy[cyc]));
      chk("last", 32'(bus.cresp.last), 32'(s_last[cyc]));
      if (s_chk[cyc]) chk("rdata", bus.cresp.data, s_dat[cyc]);
      if (!resetn) chk("reset_data", bus.cresp.data, 32'd0);
      if (mk[dbg_addr]) chk("dbg_data", dbg_data, mm[dbg_addr]);
      chk("err", 32'(err), 32'(exp_err));
      if (bus.cresp.ready && !bus.creq.is_write) begin
        obs_d.push_back(bus.cresp.data);
        obs_c.push_back(cyc);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic burst(input bit wr, input logic [31:0] addr, input int len, input bit wrap,
                       input logic [3:0] st, input int hold, input int abort_k,
                       input bit mutate, output int n);
    int idx[16];
    int first, start, nn, blk;
    @(posedge clk);
    #1;
    n = cyc;
    bus.creq.valid    = 1'b1;
    bus.creq.is_write = wr;
    bus.creq.size     = 3'd2;
    bus.creq.addr     = addr;
    bus.creq.len      = mlen_t'(len);
    bus.creq.burst    = wrap ? CBUS_WRAP : CBUS_INCR;
    bus.creq.strobe   = st;
    bus.creq.data     = wdat[0];
    first = n + LAT + 1;
    start = int'(addr >> 2) % MW;
    nn = len + 1;
    blk = start - (start % nn);
    for (int k = 0; k <= len; k++) begin
      idx[k] = wrap ? (blk + (start - blk + k) % nn) % MW : (start + k) % MW;
      s_rdy[first+k]  = 1'b1;
      s_last[first+k] = (k == len);
      s_chk[first+k]  = !wr;
      s_dat[first+k]  = mm[idx[k]];
    end
    if (mutate) begin
      wait_cyc(n + 1);
      bus.creq.addr = addr ^ 32'h100;
      wait_cyc(n + 2);
`ifdef CBUS_RAM_CHECK_EN
      exp_err = 1'b1;
`endif
    end
    for (int k = 0; k <= len; k++) begin
      wait_cyc(first + k);
      if (k == abort_k) begin
        resetn = 1'b0;
        bus.creq.valid = 1'b0;
        for (int j = k; j <= len; j++) begin
          s_rdy[first+j] = 1'b0;
          s_last[first+j] = 1'b0;
          s_chk[first+j] = 1'b0;
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        return;
      end
      bus.creq.data = wdat[k];
      @(posedge clk);
      #1;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) mm[idx[k]][b*8 +: 8] = wdat[k][b*8 +: 8];
        mk[idx[k]] = mk[idx[k]] | (st == 4'hF);
      end
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.creq.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.creq = '0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Preload through the bus.
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    burst(1, 32'h10, 3, 0, 4'hF, 0, -1, 0, n);
    wdat[0] = 32'h12345678;
    burst(1, 32'h20, 0, 0, 4'hF, 0, -1, 0, n);
    wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC; wdat[3] = 32'hD;
    burst(1, 32'h30, 3, 0, 4'hF, 0, -1, 0, n);
    for (int k = 0; k < 8; k++) wdat[k] = 32'h6400_0000 + 32'(k);
    burst(1, 32'h100, 7, 0, 4'hF, 0, -1, 0, n);

    // Strobed single-beat write, debug port watching the same word.
    dbg_addr = 10'd8;
    wdat[0] = 32'hAABBCCDD;
    burst(1, 32'h20, 0, 0, 4'b0101, 0, -1, 0, n);
    chk("mem8_strobe", dbg_data, 32'h12BB56DD);

    // INCR read and first-beat latency.
    obs_d.delete(); obs_c.delete();
    burst(0, 32'h10, 3, 0, 4'h0, 0, -1, 0, n);
    chk("incr_beats", 32'(obs_d.size()), 32'd4);
    chk("incr_lat", 32'(obs_c[0] - n), 32'd3);
    chk("incr_b0", obs_d[0], 32'h11);
    chk("incr_b3", obs_d[3], 32'h44);

    // WRAP read starting mid-block.
    obs_d.delete(); obs_c.delete();
    burst(0, 32'h38, 3, 1, 4'h0, 0, -1, 0, n);
    chk("wrap_b0", obs_d[0], 32'hC);
    chk("wrap_b1", obs_d[1], 32'hD);
    chk("wrap_b2", obs_d[2], 32'hA);
    chk("wrap_b3", obs_d[3], 32'hB);

    // Valid held after last, then an immediate new request.
    obs_d.delete(); obs_c.delete();
    burst(0, 32'h20, 0, 0, 4'h0, 5, -1, 0, n);
    burst(0, 32'h14, 0, 0, 4'h0, 0, -1, 0, n);
    chk("hold_beats", 32'(obs_d.size()), 32'd2);
    chk("hold_next", obs_d[1], 32'h22);

    // Wrap at the top of RAM.
    wdat[0] = 32'hFEED0001; wdat[1] = 32'hFEED0002;
    burst(1, 32'hFFC, 1, 0, 4'hF, 0, -1, 0, n);
    dbg_addr = 10'd0;
    #1;
    chk("top_wrap0", dbg_data, 32'hFEED0002);
    obs_d.delete(); obs_c.delete();
    burst(0, 32'hFFC, 1, 0, 4'h0, 0, -1, 0, n);
    chk("top_rd1", obs_d[1], 32'hFEED0002);

    // Reset during beat 2 of an 8-beat write.
    for (int k = 0; k < 8; k++) wdat[k] = 32'hD000_0000 + 32'(k);
    burst(1, 32'h100, 7, 0, 4'hF, 0, 2, 0, n);
    for (int i = 64; i < 72; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk("abort_mem", dbg_data, mm[i]);
    end
    dbg_addr = 10'd65;
    #1;
    chk("abort_w1", dbg_data, 32'hD0000001);
    dbg_addr = 10'd66;
    #1;
    chk("abort_w2", dbg_data, 32'h64000002);

    // Request changed during WAIT: beats follow the original address.
    obs_d.delete(); obs_c.delete();
    burst(0, 32'h10, 3, 0, 4'h0, 0, -1, 1, n);
    chk("mut_b0", obs_d[0], 32'h11);
    chk("mut_b2", obs_d[2], 32'h33);
    repeat (3) @(posedge clk);
    #1;
`ifdef CBUS_RAM_CHECK_EN
    chk("err_sticky", 32'(err), 32'd1);
`else
    chk("err_tied", 32'(err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cbus_ram_responder.md
Name: cbus_ram_responder

Overview:
- Responder end of the cache bus (cbus): accepts `cbus_req_t` bursts from a cache initiator and answers with `cbus_resp_t` beats.
- Backed by internal word-addressed RAM, with configurable first-beat latency.
- Used as the memory model under the cache test top, and as a stand-in for the AXI bridge in cache-only simulation.
- Exposes a side debug read port so the simulator can inspect memory without the bus.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the backing RAM (power of two).
- LATENCY, 2, idle cycles between request acceptance and the first beat (0 allowed).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- creq  in  cbus_req_t  request from initiator: valid, is_write, size, addr, strobe, data, len, burst.
- cresp  out  cbus_resp_t  response: ready, last, data.
- dbg_addr  in  $clog2(MEM_WORDS)  debug word index.
- dbg_data  out  32  combinational mem[dbg_addr].
- err  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset: state=IDLE, ready=0, last=0, cresp.data=0, err=0, beat counter=0. RAM contents are not reset.
- Reset asserted mid-burst aborts to IDLE; no partial write is undone.
- IDLE: on creq.valid=1, latch addr, len, burst, is_write.
  - Next state is WAIT with counter=LATENCY, or BURST directly if LATENCY=0.
  - ready=0 throughout IDLE.
- WAIT: decrement counter each cycle; at 0, move to BURST.
- BURST: one beat per cycle, ready=1.
  - Word index = (latched addr >> 2) + beat, modulo MEM_WORDS (silent wrap at the top of RAM).
  - INCR: index increments by one per beat.
  - WRAP: index wraps within the block of (len+1) words aligned to (len+1)*4 bytes. len+1 must be 1/2/4/8/16.
  - Read beat: cresp.data = mem[index], driven in the same cycle ready=1.
  - Write beat: on the ready=1 edge, byte lanes of mem[index] with strobe[i]=1 take creq.data; other lanes are unchanged. strobe=0 writes nothing.
  - last=1 on the beat where beat==len; len=0 gives a single beat with ready=last=1.
  - After the last beat, go to DRAIN.
- DRAIN: ready=0, last=0. Remain until creq.valid=0, then go to IDLE.
  - This prevents re-accepting a request the initiator has not yet dropped.
  - A new request is accepted no earlier than the cycle after valid falls.
- Back-to-back request turnaround: at least 2 idle cycles.
- Simultaneous debug read and bus write to the same word: dbg_data shows the old value until the clock edge.
- size is latched but does not alter the access; strobe alone governs bytes written.

Optional Feature:
- Macro: CBUS_RAM_CHECK_EN.
- Defined: during WAIT and BURST, any change in creq.addr, len, burst or is_write, or creq.valid falling before last, sets err=1.
  - err stays set until reset.
  - The burst continues unchanged using the latched values.
  - A simulation-only `$error` is issued.
- Undefined: err is tied 0 and no checking logic is built.

Decomposition:
- Shared package: cbus_req_t, cbus_resp_t, mlen_t, burst encodings (INCR, WRAP), strobe type. All of these already exist in the common header.
- Add to the package: the responder state enum (IDLE, WAIT, BURST, DRAIN).
- Sub-module: cbus_ram_bank, a single-port byte-strobed RAM with a second asynchronous read port for debug. All FSM logic stays in the top module.

Test Plan:
- Preload mem[4..7]=0x11,0x22,0x33,0x44. Read INCR addr=0x10, len=3, LATENCY=2 → ready first high 3 cycles after valid; data 0x11,0x22,0x33,0x44; last on the 4th beat only.
- Write INCR addr=0x20, len=0, data=0xAABBCCDD, strobe=0b0101 over mem[8]=0x12345678 → mem[8]=0x12BB56DD; ready=last=1 in the same cycle.
- Read WRAP addr=0x38, len=3 with mem[12..15]=A,B,C,D → beats C,D,A,B.
- Hold valid high 5 cycles after last → no second burst; ready stays 0 until valid drops, then a new request is accepted.
- Assert resetn=0 during beat 2 of a len=7 write → ready/last=0 immediately; words for beats 0–1 are written, later words unchanged.
- With CBUS_RAM_CHECK_EN: change addr during WAIT → err=1 and stays 1; beats still come from the original addr. Without the macro: err=0.
